// File: rtl/online_add_sequencer_r4_if.sv
`default_nettype none
// ============================================================================
//  Module      : online_add_sequencer_r4_if
//  Description : Bundle between a host/adder environment and the radix-4
//                online-addition sequencer.
//                Host side   : start, abort, x_in, y_in -> busy, done, result
//                Adder side  : zi -> adder_reset, adder_en, xi, yi
//                The master modport is the environment (host plus adder);
//                the slave modport is the sequencer.
//  Revision    : 1.0  initial release
// ============================================================================
interface online_add_sequencer_r4_if #(
  parameter int N = 6,
  parameter int C = 3
);
  logic                 start;
  logic                 abort;
  logic [N*C-1:0]       x_in;
  logic [N*C-1:0]       y_in;
  logic                 busy;
  logic                 done;
  logic [(N+1)*C-1:0]   result;
  logic                 adder_reset;
  logic                 adder_en;
  logic [C-1:0]         xi;
  logic [C-1:0]         yi;
  logic [C-1:0]         zi;

  modport master (
    output start, abort, x_in, y_in, zi,
    input  busy, done, result, adder_reset, adder_en, xi, yi
  );

  modport slave (
    input  start, abort, x_in, y_in, zi,
    output busy, done, result, adder_reset, adder_en, xi, yi
  );
endinterface
`default_nettype wire

// File: rtl/online_add_sequencer_r4.sv
`default_nettype none
// ============================================================================
//  Module      : online_add_sequencer_r4
//  Description : Runs one radix-4 online addition on an external adder.
//                Latches two N-digit signed-digit operands on start, clears
//                the adder for one cycle, streams the digits MSD-first
//                followed by DELAY zero digits, gathers the N+1 sum digits
//                from zi and raises done for one cycle.
//  Ports       : clk    - system clock, rising edge
//                rst_n  - asynchronous active-low reset
//                bus    - slave modport: start/abort/x_in/y_in in,
//                         busy/done/result out, adder_reset/adder_en/xi/yi
//                         out to the adder, zi in from the adder
//  Parameters  : N digits per operand, C bits per digit, DELAY online delay
//                of the adder (valid range 1..N)
//  Revision    : 1.0  initial release
// ============================================================================
module online_add_sequencer_r4 #(
  parameter int N     = 6,
  parameter int C     = 3,
  parameter int DELAY = 2
) (
  input wire                         clk,
  input wire                         rst_n,
  online_add_sequencer_r4_if.slave   bus
);

  localparam int STEPS = N + DELAY;
  localparam int SW    = $clog2(N + DELAY + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CLEAR = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t               state_q;
  logic [SW-1:0]        step_q;
  logic [N*C-1:0]       x_q;
  logic [N*C-1:0]       y_q;
  logic [(N+1)*C-1:0]   result_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 adder_reset_q;
  logic                 adder_en_q;
  logic [C-1:0]         xi_q;
  logic [C-1:0]         yi_q;

  logic [SW-1:0]        step_d;
  logic [C-1:0]         xi_d;
  logic [C-1:0]         yi_d;
  logic                 last_step;

  assign step_d    = step_q + SW'(1);
  assign last_step = (step_q == SW'(STEPS - 1));

  // Digit fed during the next step: latched digit N-1-step_d, or zero once
  // every operand digit has gone out (flushing the adder's delay).
  always_comb begin
    xi_d = '0;
    yi_d = '0;
    for (int k = 0; k < N; k++) begin
      if (int'(step_d) == N - 1 - k) begin
        xi_d = x_q[C*k +: C];
        yi_d = y_q[C*k +: C];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      step_q        <= '0;
      x_q           <= '0;
      y_q           <= '0;
      result_q      <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      adder_reset_q <= 1'b0;
      adder_en_q    <= 1'b0;
      xi_q          <= '0;
      yi_q          <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q        <= 1'b0;
          adder_reset_q <= 1'b0;
          if (bus.start) begin
            x_q           <= bus.x_in;
            y_q           <= bus.y_in;
            result_q      <= '0;
            busy_q        <= 1'b1;
            adder_reset_q <= 1'b1;
            state_q       <= S_CLEAR;
          end
        end

        S_CLEAR: begin
          if (bus.abort) begin
            // adder_reset is already high; it stays up for the abort cycle
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else begin
            state_q       <= S_RUN;
            step_q        <= '0;
            adder_reset_q <= 1'b0;
            adder_en_q    <= 1'b1;
            xi_q          <= x_q[C*(N-1) +: C];
            yi_q          <= y_q[C*(N-1) +: C];
          end
        end

        S_RUN: begin
          if (bus.abort) begin
            // Partial result digits are kept; this step's zi is dropped.
            state_q       <= S_IDLE;
            busy_q        <= 1'b0;
            adder_en_q    <= 1'b0;
            adder_reset_q <= 1'b1;
            xi_q          <= '0;
            yi_q          <= '0;
          end else begin
            // Step s delivers sum digit STEPS-1-s; steps before DELAY-1
            // match no digit, so their zi is ignored.
            for (int j = 0; j <= N; j++) begin
              if (int'(step_q) == STEPS - 1 - j) begin
                result_q[C*j +: C] <= bus.zi;
              end
            end
            if (last_step) begin
              // step_q is left at its final value until the next run
              state_q    <= S_DONE;
              busy_q     <= 1'b0;
              done_q     <= 1'b1;
              adder_en_q <= 1'b0;
              xi_q       <= '0;
              yi_q       <= '0;
            end else begin
              step_q <= step_d;
              xi_q   <= xi_d;
              yi_q   <= yi_d;
            end
          end
        end

        S_DONE: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.result      = result_q;
  assign bus.adder_reset = adder_reset_q;
  assign bus.adder_en    = adder_en_q;
  assign bus.xi          = xi_q;
  assign bus.yi          = yi_q;

endmodule
`default_nettype wire

// File: tb/tb_online_add_sequencer_r4.sv
`default_nettype none
// ============================================================================
//  Module      : tb_online_add_sequencer_r4
//  Description : Self-checking bench for online_add_sequencer_r4 with a
//                value-level radix-4 online adder (delay 2) driving zi.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_online_add_sequencer_r4;

  localparam int N     = 6;
  localparam int C     = 3;
  localparam int DELAY = 2;
  localparam int RW    = (N + 1) * C;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  online_add_sequencer_r4_if #(.N(N), .C(C)) bus ();

  online_add_sequencer_r4 #(.N(N), .C(C), .DELAY(DELAY)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // every DUT output in one vector
  logic [RW+2*C+3:0] outs;
  assign outs = {bus.busy, bus.done, bus.adder_reset, bus.adder_en,
                 bus.xi, bus.yi, bus.result};

  function automatic int sd(input logic [C-1:0] d);
    return int'($signed(d));
  endfunction

  function automatic longint opval(input logic [N*C-1:0] v);
    longint acc = 0;
    for (int k = N - 1; k >= 0; k--) acc = acc * 4 + longint'(sd(v[C*k +: C]));
    return acc;
  endfunction

  function automatic longint resval(input logic [RW-1:0] v);
    longint acc = 0;
    for (int k = N; k >= 0; k--) acc = acc * 4 + longint'(sd(v[C*k +: C]));
    return acc;
  endfunction

  function automatic logic [N*C-1:0] rand_ops();
    logic [N*C-1:0] v;
    for (int k = 0; k < N; k++) v[C*k +: C] = C'($urandom_range(0, 7));
    return v;
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // ---------------- adder model ----------------
  // Residual-based online adder: residual r grows by 4r + x + y each step and
  // emits the nearest multiple of 16 as the output digit. Step 0 always
  // emits 0, and after two zero-padding steps the residual is exactly zero,
  // so the emitted digits (weight 4^(N+1-s)) sum to X + Y.
  int add_r;
  int add_v;
  int add_e;
  always_comb begin
    add_v = 4 * add_r + sd(bus.xi) + sd(bus.yi);
    add_e = (add_v + 8) >>> 4;
  end
  assign bus.zi = bus.adder_en ? add_e[C-1:0] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)               add_r <= 0;
    else if (bus.adder_reset) add_r <= 0;
    else if (bus.adder_en)    add_r <= add_v - 16 * add_e;
  end

  // ---------------- one transaction against the timeline ----------------
  // Cycle c counts from the edge that accepts start (cycle 1 = CLEAR).
  task automatic run_op(input logic [N*C-1:0] x, input logic [N*C-1:0] y,
                        input int restart_cyc, input int abort_step);
    logic [RW-1:0] exp_res;
    logic [RW-1:0] mask;
    logic [C-1:0]  exi;
    logic [C-1:0]  eyi;
    int            ab_c;
    int            s;
    bit            normal;
    exp_res = '0;
    mask    = '1;
    ab_c    = (abort_step >= 0) ? abort_step + 2 : 1000;
    if (abort_step >= DELAY - 1 && abort_step <= N + DELAY - 1)
      mask[C*(N+DELAY-1-abort_step) +: C] = '0;

    @(negedge clk);
    bus.x_in  = x;
    bus.y_in  = y;
    bus.start = 1'b1;
    bus.abort = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      normal = (c <= ab_c);
      s      = c - 2;
      exi    = '0;
      eyi    = '0;
      if (normal && s >= 0 && s < N) begin
        exi = x[C*(N-1-s) +: C];
        eyi = y[C*(N-1-s) +: C];
      end
      check_eq("busy",        bus.busy,        normal && c <= N + DELAY + 1);
      check_eq("adder_reset", bus.adder_reset, normal ? (c == 1) : (c == ab_c + 1));
      check_eq("adder_en",    bus.adder_en,    normal && c >= 2 && c <= N + DELAY + 1);
      check_eq("xi",          bus.xi,          exi);
      check_eq("yi",          bus.yi,          eyi);
      check_eq("done",        bus.done,        normal && c == N + DELAY + 2);
      if (s >= DELAY - 1 && s <= N + DELAY - 1 && c < ab_c)
        exp_res[C*(N+DELAY-1-s) +: C] = bus.zi;
      bus.start = (c == restart_cyc);
      bus.abort = (abort_step >= 0 && c == ab_c);
      if (c == 1) begin
        bus.x_in = rand_ops();
        bus.y_in = rand_ops();
      end
    end
    bus.start = 1'b0;
    bus.abort = 1'b0;
    check_eq("result", bus.result & mask, exp_res & mask);
    if (abort_step < 0)
      check_eq("sum_value", resval(bus.result), opval(x) + opval(y));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N*C-1:0] xo;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.x_in  = '0;
    bus.y_in  = '0;
    rst_n     = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("reset_state", outs, '0);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check_eq("idle", outs, '0);
    end

    // zero sum
    run_op('0, '0, 0, -1);

    // digit ordering: MSD..LSD = 1,2,3,-1,-2,0
    xo = {3'd1, 3'd2, 3'd3, 3'b111, 3'b110, 3'b000};
    run_op(xo, '0, 0, -1);

    // start while busy, then start during DONE: both ignored
    run_op(rand_ops(), rand_ops(), 4, -1);
    run_op(rand_ops(), rand_ops(), N + DELAY + 2, -1);

    // abort mid-run, at the first step and at the last step
    run_op(rand_ops(), rand_ops(), 0, 3);
    run_op(rand_ops(), rand_ops(), 0, -1);
    run_op(rand_ops(), rand_ops(), 0, 0);
    run_op(rand_ops(), rand_ops(), 0, N + DELAY - 1);
    run_op(rand_ops(), rand_ops(), 0, -1);

    // asynchronous reset during step 5
    @(negedge clk);
    bus.x_in  = rand_ops();
    bus.y_in  = rand_ops();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (6) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_eq("async_reset", outs, '0);
    repeat (2) @(negedge clk);
    check_eq("held_in_reset", outs, '0);
    rst_n = 1'b1;
    run_op(rand_ops(), rand_ops(), 0, -1);

    // random operands
    for (int i = 0; i < 12; i++) run_op(rand_ops(), rand_ops(), 0, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
